// File: rtl/hx8352_pkg.sv
`default_nettype none
// ============================================================================
// Module : hx8352_pkg
// Desc   : Shared command codes, ROM field positions and sequencer states.
// Rev    : 1.0  initial release
// ============================================================================
package hx8352_pkg;

    localparam logic [7:0] CMD_CUSTOM_DELAY = 8'hFE;
    localparam logic [7:0] CMD_CUSTOM_DONE  = 8'hFF;

    localparam int CMD_MSB = 23;
    localparam int CMD_LSB = 16;
    localparam int VAL_MSB = 15;
    localparam int VAL_LSB = 0;

    // Wide enough for the longest reset wait in microseconds
    localparam int US_W = 17;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RST_LOW  = 4'd1,
        ST_RST_WAIT = 4'd2,
        ST_FETCH    = 4'd3,
        ST_ROM_WAIT = 4'd4,
        ST_DECODE   = 4'd5,
        ST_WRITE    = 4'd6,
        ST_DELAY    = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hx8352_init_seq_us_timer.sv
`default_nettype none
// ============================================================================
// Module : us_timer
// Desc   : Microsecond down-counter with prescaler; expired pulses on last cycle.
// Rev    : 1.0  initial release
// ============================================================================
module us_timer
    import hx8352_pkg::*;
#(
    parameter int CLKS_PER_US = 50
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [US_W-1:0] count_us,
    output logic            expired
);

    localparam int              PRE_W   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_US - 1);

    logic [US_W-1:0]  r_us;
    logic [PRE_W-1:0] r_pre;
    logic             r_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_us     <= '0;
            r_pre    <= '0;
            r_active <= 1'b0;
        end else if (load) begin
            r_us     <= count_us;
            r_pre    <= PRE_MAX;
            r_active <= (count_us != '0);
        end else if (r_active) begin
            if (r_pre == '0) begin
                r_pre <= PRE_MAX;
                r_us  <= r_us - US_W'(1);
                if (r_us == US_W'(1)) begin
                    r_active <= 1'b0;
                end
            end else begin
                r_pre <= r_pre - PRE_W'(1);
            end
        end
    end

    // Fires during the final counted cycle so the owner leaves after exactly N*CLKS_PER_US cycles
    assign expired = r_active && (r_pre == '0) && (r_us == US_W'(1));

endmodule
`default_nettype wire

// File: rtl/hx8352_init_seq.sv
`default_nettype none
// ============================================================================
// Module : hx8352_init_seq
// Desc   : Walks the HX8352 init ROM: panel reset, register writes, delays.
// Rev    : 1.0  initial release
// ============================================================================
module hx8352_init_seq
    import hx8352_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int RST_LOW_US  = 10_000,
    parameter int RST_WAIT_US = 120_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [7:0]  wr_cmd,
    output logic [15:0] wr_data,
    output logic        lcd_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;

    state_t          r_state;
    state_t          w_next;
    logic            w_load;
    logic [US_W-1:0] w_load_us;
    logic            w_expired;
    logic            w_start_ok;
    logic            w_issue;
    logic            w_advance;
    logic            w_last;
    logic [7:0]      w_cmd;
    logic [15:0]     w_val;
    logic            w_unused_hi;

    assign w_cmd       = rom_data[CMD_MSB:CMD_LSB];
    assign w_val       = rom_data[VAL_MSB:VAL_LSB];
    assign w_unused_hi = ^rom_data[31:24];
    assign w_last      = (rom_addr == 8'hFF);
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done        = (r_state == ST_DONE);

    us_timer #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .count_us (w_load_us),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_us  = '0;
        w_start_ok = 1'b0;
        w_issue    = 1'b0;
        w_advance  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start_ok = 1'b1;
                    w_load     = 1'b1;
                    w_load_us  = US_W'(RST_LOW_US);
                    w_next     = ST_RST_LOW;
                end
            end
            ST_RST_LOW: begin
                if (w_expired) begin
                    w_load    = 1'b1;
                    w_load_us = US_W'(RST_WAIT_US);
                    w_next    = ST_RST_WAIT;
                end
            end
            ST_RST_WAIT: begin
                if (w_expired) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH:    w_next = ST_ROM_WAIT;
            ST_ROM_WAIT: w_next = ST_DECODE;
            ST_DECODE: begin
                if (w_cmd == CMD_CUSTOM_DONE) begin
                    w_next = ST_DONE;
                end else if (w_cmd == CMD_CUSTOM_DELAY) begin
                    if (w_val == 16'd0) begin
                        w_advance = 1'b1;
                    end else begin
                        w_load    = 1'b1;
                        w_load_us = {1'b0, w_val};
                        w_next    = ST_DELAY;
                    end
                end else begin
                    w_issue = 1'b1;
                    w_next  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    w_advance = 1'b1;
                end
            end
            ST_DELAY: begin
                if (w_expired) begin
                    w_advance = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // The last ROM slot has no successor, so finishing it ends the run
        if (w_advance) begin
            w_next = w_last ? ST_DONE : ST_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr  <= '0;
            wr_valid  <= 1'b0;
            wr_cmd    <= '0;
            wr_data   <= '0;
            lcd_rst_n <= 1'b1;
            err       <= 1'b0;
        end else begin
            if (w_start_ok) begin
                lcd_rst_n <= 1'b0;
                err       <= 1'b0;
                rom_addr  <= '0;
            end
            if ((r_state == ST_RST_LOW) && w_expired) begin
                lcd_rst_n <= 1'b1;
            end
            if (w_issue) begin
                wr_cmd   <= w_cmd;
                wr_data  <= w_val;
                wr_valid <= 1'b1;
            end
            if ((r_state == ST_WRITE) && wr_ready) begin
                wr_valid <= 1'b0;
            end
            if (w_advance) begin
                if (w_last) begin
                    err <= 1'b1;
                end else begin
                    rom_addr <= rom_addr + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hx8352_init_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_hx8352_init_seq
// Desc   : Self-checking bench: ROM tables, entry-dwell scoreboard, corner cases.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hx8352_init_seq;

    typedef struct {
        logic [31:0] word;
        int          stall;
        logic        is_write;
        int          dwell;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic        is_write;
        logic [7:0]  cmd;
        logic [15:0] data;
        int          dwell;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_cmd;
    logic [15:0] wr_data;
    logic        lcd_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    logic [31:0] rom [256];
    int          stall_of [256];
    vec_t        tv [7];
    logic        mon_en = 1'b0;
    int          dwell_cnt = 0;
    logic [7:0]  prev_addr = 8'h00;
    logic        prev_v = 1'b0;
    int          stall_left = 0;

    hx8352_init_seq #(
        .CLK_FREQ_HZ (4_000_000),
        .RST_LOW_US  (3),
        .RST_WAIT_US (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_cmd    (wr_cmd),
        .wr_data   (wr_data),
        .lcd_rst_n (lcd_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int i, input logic [31:0] w, input logic wr, input int dw);
        exp_t x;
        x.addr     = 8'(i);
        x.is_write = wr;
        x.cmd      = w[23:16];
        x.data     = w[15:0];
        x.dwell    = dw;
        sbq.push_back(x);
    endtask

    task automatic load_a();
        sbq.delete();
        for (int i = 0; i < 256; i++) begin
            rom[i]      = 32'h00FF_0000;
            stall_of[i] = 0;
        end
        for (int i = 0; i < 7; i++) begin
            rom[i]      = tv[i].word;
            stall_of[i] = tv[i].stall;
            push(i, tv[i].word, tv[i].is_write, tv[i].dwell);
        end
    endtask

    // 256 plain writes and no Done entry: the run must end on the last slot
    task automatic load_b();
        logic [31:0] w;
        sbq.delete();
        for (int i = 0; i < 256; i++) begin
            w           = {8'h00, 8'h10 + 8'(i % 128), 16'(i * 3 + 256)};
            rom[i]      = w;
            stall_of[i] = 0;
            push(i, w, 1'b1, (i == 0) ? 24 : 4);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic power_up();
        int low;
        int n;
        int busy_bad;
        pulse_start();
        chk("lcd_low_next_cycle", lcd_rst_n, 0);
        chk("busy_after_start", busy, 1);
        chk("err_cleared_by_start", err, 0);
        chk("rom_addr_after_start", rom_addr, 0);
        low = 0; n = 0; busy_bad = 0;
        while (lcd_rst_n == 1'b0 && n < 100) begin
            low++;
            if (!busy) busy_bad++;
            tick();
            n++;
        end
        chk("lcd_low_cycles", low, 12);
        chk("busy_during_reset_low", busy_bad, 0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", done, 1);
    endtask

    task automatic final_checks(input logic [7:0] addr, input logic err_exp);
        chk("done_flag", done, 1);
        chk("busy_in_done", busy, 0);
        chk("err_flag", err, err_exp);
        chk("final_rom_addr", rom_addr, addr);
        chk("lcd_rst_n_in_done", lcd_rst_n, 1);
        chk("entries_left", sbq.size(), 1);
        if (sbq.size() > 0) chk("last_entry_dwell", dwell_cnt, sbq[0].dwell);
        sbq.delete();
    endtask

    // Tracks cycles spent on each ROM address and checks writes against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!lcd_rst_n) begin
                    dwell_cnt = 0;
                end else if (rom_addr != prev_addr) begin
                    if (sbq.size() == 0) begin
                        chk("sb_underflow", sbq.size(), 1);
                    end else begin
                        e = sbq.pop_front();
                        chk("entry_dwell", dwell_cnt, e.dwell);
                        chk("next_rom_addr", rom_addr, 8'(e.addr + 8'd1));
                    end
                    dwell_cnt = 1;
                end else if (busy) begin
                    dwell_cnt++;
                end
                if (wr_valid) begin
                    if (sbq.size() == 0) begin
                        chk("sb_underflow_wr", sbq.size(), 1);
                    end else begin
                        chk("wr_expected", 1, sbq[0].is_write);
                        chk("wr_cmd", wr_cmd, sbq[0].cmd);
                        chk("wr_data", wr_data, sbq[0].data);
                    end
                end
            end
            prev_addr = rom_addr;
        end
    end

    // Bus-writer model: stalls each write by its table-given number of cycles
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (wr_valid && !prev_v) stall_left = stall_of[rom_addr];
            prev_v = wr_valid;
            if (wr_valid && stall_left > 0) begin
                wr_ready = 1'b0;
                stall_left--;
            end else begin
                wr_ready = 1'b1;
            end
        end
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        tv[0] = '{32'h0083_0002, 5, 1'b1, 29};
        tv[1] = '{32'h00FE_000A, 0, 1'b0, 43};
        tv[2] = '{32'h00FE_0000, 0, 1'b0, 3};
        tv[3] = '{32'hAB22_00C5, 0, 1'b1, 4};
        tv[4] = '{32'h0017_1234, 2, 1'b1, 6};
        tv[5] = '{32'h00FE_0001, 0, 1'b0, 7};
        tv[6] = '{32'h00FF_0000, 0, 1'b0, 3};
        for (int i = 0; i < 256; i++) begin
            rom[i]      = 32'h00FF_0000;
            stall_of[i] = 0;
        end
        repeat (3) tick();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_cmd", wr_cmd, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_lcd_rst_n", lcd_rst_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        load_a();
        mon_en = 1'b1;
        power_up();
        repeat (8) tick();
        pulse_start();
        chk("start_ignored_in_rst_wait", lcd_rst_n, 1);
        repeat (30) tick();
        pulse_start();
        chk("start_ignored_in_delay", lcd_rst_n, 1);
        chk("busy_in_delay", busy, 1);
        wait_done(2000);
        final_checks(8'd6, 1'b0);

        load_b();
        power_up();
        wait_done(3000);
        final_checks(8'hFF, 1'b1);

        load_a();
        power_up();
        n = 0;
        while (!wr_valid && n < 200) begin
            tick();
            n++;
        end
        chk("wr_valid_seen", wr_valid, 1);
        tick();
        chk("still_in_write", wr_valid, 1);
        mon_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_wr_valid", wr_valid, 0);
        chk("async_rst_lcd_rst_n", lcd_rst_n, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rom_addr", rom_addr, 0);
        chk("async_rst_wr_cmd", wr_cmd, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("idle_after_rst_done", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
